// File: rtl/conf_int_pkg.sv
// Shared FSM state encoding and default parameter values for the conf_int accumulator.
package conf_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_OP_BITWIDTH        = 16;
    localparam int DEF_DATA_PATH_BITWIDTH = 16;
    localparam int DEF_ACC_BITWIDTH       = 32;
    localparam int DEF_LEN_BITWIDTH       = 8;
    localparam int DEF_APX_DROP           = 4;

endpackage

// File: rtl/conf_int_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags overflow on carry-out.
// Purely combinational, zero latency, no flow control.
module conf_int_sat_add
    import conf_int_pkg::*;
#(
    parameter int ACC_BITWIDTH = DEF_ACC_BITWIDTH
) (
    input  logic [ACC_BITWIDTH-1:0] a,
    input  logic [ACC_BITWIDTH-1:0] b,
    output logic [ACC_BITWIDTH-1:0] sum,
    output logic                    overflow
);

    logic [ACC_BITWIDTH:0] raw;

    assign raw      = {1'b0, a} + {1'b0, b};
    assign overflow = raw[ACC_BITWIDTH];
    assign sum      = overflow ? {ACC_BITWIDTH{1'b1}} : raw[ACC_BITWIDTH-1:0];

endmodule

// File: rtl/conf_int_acc__noff__stream.sv
// Streaming accumulator of len products with accurate/approximate mode and saturation.
// Result valid 1 cycle after the last accepted beat; in_ready only in ACC, result held until out_ready.
module conf_int_acc__noff__stream
    import conf_int_pkg::*;
#(
    parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
    parameter int ACC_BITWIDTH       = DEF_ACC_BITWIDTH,
    parameter int LEN_BITWIDTH       = DEF_LEN_BITWIDTH,
    parameter int APX_DROP           = DEF_APX_DROP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          racc,
    input  logic                          rapx,
    input  logic                          start,
    input  logic [LEN_BITWIDTH-1:0]       len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_BITWIDTH-1:0]       sum,
    output logic                          sat,
    output logic                          busy
);

    // A product of two OP_BITWIDTH operands never drives bits above 2*OP_BITWIDTH.
    localparam int OPND_W = (DATA_PATH_BITWIDTH < 2 * OP_BITWIDTH) ?
                            DATA_PATH_BITWIDTH : 2 * OP_BITWIDTH;
    localparam logic [ACC_BITWIDTH-1:0] APX_MASK =
        ~((ACC_BITWIDTH'(1) << APX_DROP) - ACC_BITWIDTH'(1));

    state_t                  state;
    logic [LEN_BITWIDTH-1:0] cnt;
    logic                    apx;
    logic [ACC_BITWIDTH-1:0] acc;
    logic                    sat_r;

    logic [ACC_BITWIDTH-1:0] d_ext;
    logic [ACC_BITWIDTH-1:0] opnd;
    logic [ACC_BITWIDTH-1:0] add_sum;
    logic                    add_ovf;
    logic                    beat;

    assign d_ext = ACC_BITWIDTH'(d[OPND_W-1:0]);
    assign opnd  = apx ? (d_ext & APX_MASK) : d_ext;
    assign beat  = in_valid && in_ready;

    conf_int_sat_add #(
        .ACC_BITWIDTH(ACC_BITWIDTH)
    ) u_sat_add (
        .a       (acc),
        .b       (opnd),
        .sum     (add_sum),
        .overflow(add_ovf)
    );

    // Handshake outputs decode the state register only, never the inputs.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = acc;
    assign sat       = sat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            apx   <= 1'b0;
            acc   <= '0;
            sat_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        sat_r <= 1'b0;
                        cnt   <= len;
                        apx   <= rapx && !racc;
                        state <= (len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc   <= add_sum;
                        sat_r <= sat_r || add_ovf;
                        cnt   <= cnt - LEN_BITWIDTH'(1);
                        if (cnt == LEN_BITWIDTH'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conf_int_acc__noff__stream.sv
module tb_conf_int_acc__noff__stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        racc = 1'b0;
    logic        rapx = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] d = 16'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, sat, busy;
    logic [31:0] sum;
    logic        in_ready16, out_valid16, sat16, busy16;
    logic [15:0] sum16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conf_int_acc__noff__stream dut (
        .clk(clk), .rst_n(rst_n), .racc(racc), .rapx(rapx), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .d(d), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .sat(sat), .busy(busy)
    );

    conf_int_acc__noff__stream #(.ACC_BITWIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .racc(racc), .rapx(rapx), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .d(d), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .sat(sat16), .busy(busy16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: phase 0 idle, 1 collecting, 2 result pending.
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX16 = 64'hFFFF;

    int     m_phase = 0;
    int     m_left = 0;
    bit     m_apx = 1'b0;
    longint m_s32 = 0;
    longint m_s16 = 0;
    bit     m_t32 = 1'b0;
    bit     m_t16 = 1'b0;

    function automatic longint op_of(input longint dv, input bit ax);
        return ax ? dv - (dv % 16) : dv;
    endfunction

    function automatic longint sadd(input longint s, input longint o, input longint mx);
        return (s + o > mx) ? mx : s + o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_apx <= 1'b0;
            m_s32 <= 0; m_s16 <= 0; m_t32 <= 1'b0; m_t16 <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_left  <= int'(len);
                    m_apx   <= rapx && !racc;
                    m_s32   <= 0; m_s16 <= 0; m_t32 <= 1'b0; m_t16 <= 1'b0;
                    m_phase <= (len == 8'd0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    m_s32  <= sadd(m_s32, op_of(longint'(d), m_apx), MAX32);
                    m_s16  <= sadd(m_s16, op_of(longint'(d), m_apx), MAX16);
                    m_t32  <= m_t32 || (m_s32 + op_of(longint'(d), m_apx) > MAX32);
                    m_t16  <= m_t16 || (m_s16 + op_of(longint'(d), m_apx) > MAX16);
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 1});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
        check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
        check("sum", {32'd0, sum}, m_s32);
        check("sat", {63'd0, sat}, {63'd0, m_t32});
        check("in_ready16", {63'd0, in_ready16}, {63'd0, m_phase == 1});
        check("out_valid16", {63'd0, out_valid16}, {63'd0, m_phase == 2});
        check("busy16", {63'd0, busy16}, {63'd0, m_phase != 0});
        check("sum16", {48'd0, sum16}, m_s16);
        check("sat16", {63'd0, sat16}, {63'd0, m_t16});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l, input logic ra, input logic rx);
        start = 1'b1; len = l; racc = ra; rapx = rx;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] dv);
        in_valid = 1'b1; d = dv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int n_acc;

    initial begin
        #1;
        check("reset_sum", {32'd0, sum}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 100+200+300, result visible right after the third accepting edge
        do_start(8'd3, 1'b1, 1'b0);
        check("t1_in_ready", {63'd0, in_ready}, 64'd1);
        beat(16'd100);
        beat(16'd200);
        check("t1_not_early", {63'd0, out_valid}, 64'd0);
        beat(16'd300);
        check("t1_out_valid", {63'd0, out_valid}, 64'd1);
        check("t1_sum", {32'd0, sum}, 64'd600);
        check("t1_sat", {63'd0, sat}, 64'd0);
        drain();
        check("t1_drop", {63'd0, out_valid}, 64'd0);

        // approximate mode, then racc priority over rapx
        do_start(8'd2, 1'b0, 1'b1);
        beat(16'h00FF); beat(16'h0013);
        check("t2_apx_sum", {32'd0, sum}, 64'h100);
        drain();
        do_start(8'd2, 1'b1, 1'b1);
        beat(16'h00FF); beat(16'h0013);
        check("t2_prio_sum", {32'd0, sum}, 64'h112);
        drain();

        // saturation in the 16-bit instance, then cleared by the next start
        do_start(8'd2, 1'b1, 1'b0);
        beat(16'hFFFF); beat(16'h0002);
        check("t3_sum16", {48'd0, sum16}, 64'hFFFF);
        check("t3_sat16", {63'd0, sat16}, 64'd1);
        check("t3_sum32", {32'd0, sum}, 64'h10001);
        drain();
        do_start(8'd1, 1'b1, 1'b0);
        beat(16'd5);
        check("t3_clear_sat16", {63'd0, sat16}, 64'd0);
        check("t3_clear_sum16", {48'd0, sum16}, 64'd5);
        drain();

        // len=0 straight to DONE, held under backpressure, start on handshake ignored
        do_start(8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t4_hold_sum", {32'd0, sum}, 64'd0);
            tick();
        end
        start = 1'b1; len = 8'd2; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("t4_idle", {63'd0, busy}, 64'd0);
        tick();
        check("t4_still_idle", {63'd0, busy}, 64'd0);

        // asynchronous reset mid-accumulation
        do_start(8'd4, 1'b1, 1'b0);
        beat(16'd9);
        check("t5_partial", {32'd0, sum}, 64'd9);
        in_valid = 1'b1; d = 16'd9;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_sum", {32'd0, sum}, 64'd0);
        check("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        check("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        do_start(8'd1, 1'b1, 1'b0);
        beat(16'd7);
        check("t5_sum", {32'd0, sum}, 64'd7);
        drain();

        // sparse in_valid with a stray start during ACC
        do_start(8'd4, 1'b1, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            d = 16'd1;
            start = (i == 3);
            len = 8'd9;
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        check("t6_accepts", 64'(n_acc), 64'd4);
        check("t6_out_valid", {63'd0, out_valid}, 64'd1);
        check("t6_sum", {32'd0, sum}, 64'd4);
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conf_int_acc__noff__stream.md
CONF_INT_ACC__NOFF__STREAM -- requirements
Module: conf_int_acc__noFF__stream

Interface
REQ-001 The block SHALL have parameter OP_BITWIDTH, default 16, meaning operator bit width of the upstream multiplier.
REQ-002 The block SHALL have parameter DATA_PATH_BITWIDTH, default 16, meaning width of each incoming product word.
REQ-003 The block SHALL have parameter ACC_BITWIDTH, default 32, meaning accumulator and result width (>= DATA_PATH_BITWIDTH).
REQ-004 The block SHALL have parameter LEN_BITWIDTH, default 8, meaning width of the beat-count field.
REQ-005 The block SHALL have parameter APX_DROP, default 4, meaning the number of product LSBs zeroed in approximate mode.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port racc, input, 1 bit: accurate-mode request, sampled at start.
REQ-010 The block SHALL have port rapx, input, 1 bit: approximate-mode request, sampled at start.
REQ-011 The block SHALL have port start, input, 1 bit: begin a new accumulation.
REQ-012 The block SHALL have port len, input, LEN_BITWIDTH bits: number of products to accumulate, sampled at start.
REQ-013 The block SHALL have port in_valid, input, 1 bit: upstream product valid.
REQ-014 The block SHALL have port in_ready, output, 1 bit: block accepts a product.
REQ-015 The block SHALL have port d, input, DATA_PATH_BITWIDTH bits: unsigned product from the multiplier stage.
REQ-016 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-018 The block SHALL have port sum, output, ACC_BITWIDTH bits: accumulated result.
REQ-019 The block SHALL have port sat, output, 1 bit: saturation occurred during this accumulation.
REQ-020 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-021 The block SHALL implement FSM states IDLE, ACC and DONE.
REQ-022 In IDLE, start=1 with len!=0 SHALL clear sum and sat, latch len into a down-counter and latch mode, then go to ACC on the next edge.
REQ-023 In IDLE, start=1 with len==0 SHALL go to DONE with sum=0 and sat=0.
REQ-024 Mode latch: approximate iff rapx=1 and racc=0; racc=1 SHALL take priority.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 in_ready SHALL equal 1 only in ACC, as a registered state decode with no combinational path from in_valid.
REQ-027 A beat SHALL be accepted on a rising edge where in_valid & in_ready; no other edge alters sum.
REQ-028 Each accepted operand SHALL be d zero-extended to ACC_BITWIDTH; in approximate mode, operand bits [APX_DROP-1:0] SHALL be forced to 0.
REQ-029 Addition SHALL be unsigned and saturating: if the true sum exceeds 2^ACC_BITWIDTH-1, sum SHALL hold all-ones and sat SHALL set, staying set until the next start.
REQ-030 The counter SHALL decrement per accepted beat; the beat taking it to 0 SHALL move the FSM to DONE on the same edge, so out_valid rises the cycle after the last accepted beat (latency 1).
REQ-031 In DONE, out_valid=1 and sum/sat SHALL be held stable until out_valid & out_ready, then the FSM SHALL return to IDLE; out_valid SHALL drop on the following cycle.
REQ-032 If out_ready is already high on DONE entry, the result SHALL be consumed in exactly one cycle.
REQ-033 start asserted in the same cycle as the DONE handshake SHALL be ignored; it is honoured only from IDLE.

Reset
REQ-034 Assertion of rst_n=0 SHALL, asynchronously and at any point including mid-accumulation, force IDLE with sum=0, sat=0, counter=0, mode=accurate, out_valid=0, in_ready=0 and busy=0.
REQ-035 Deassertion of rst_n SHALL be synchronised externally; the first accepted start SHALL come no earlier than the first clk edge after deassertion.

Structure
REQ-036 The state enum and default parameter values SHALL live in the shared package conf_int_pkg.
REQ-037 The saturating adder SHALL be the sub-module conf_int_sat_add, parameterised by ACC_BITWIDTH, purely combinational, with outputs sum and overflow.
REQ-038 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-039 start, len=3, racc=1, products 100, 200, 300 back-to-back -> out_valid one cycle after the third beat, sum=600, sat=0.
REQ-040 start, len=2, rapx=1, racc=0, d=0x00FF, 0x0013 -> sum=0x00F0+0x0010=0x0100.
REQ-041 ACC_BITWIDTH=16, len=2, d=0xFFFF, 0x0002 -> sum=0xFFFF, sat=1.
REQ-042 len=0 -> DONE with sum=0; out_ready held low 5 cycles -> out_valid and sum stable throughout, then a single handshake returns the FSM to IDLE.
REQ-043 rst_n pulsed low after 1 of 4 beats -> immediate IDLE with all outputs 0; a new start, len=1, d=7 -> sum=7.
REQ-044 in_valid toggled every other cycle with len=4, d=1 -> exactly 4 acceptances, sum=4, and a start pulse during ACC has no effect.
